// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if
//   Bundle between the multi-cycle sequencing controller and the datapath /
//   memory side.
//   master : controller view (drives the strobes, the counter and the debug state)
//   slave  : datapath/memory view (drives opcode, zero and the ready inputs)
//   Signals:
//     opcode[6:0]     instruction[6:0] from the instruction register
//     zero            ALU zero flag
//     imem_ready      instruction memory completes the request this cycle
//     dmem_ready      data memory completes the request this cycle
//     imem_req        instruction fetch request
//     ir_write        load instruction register
//     pc_write        PC <= PC + 4
//     pc_branch       PC <= branch target
//     alu_src         0 = rs2, 1 = immediate
//     alu_op[1:0]     00 add, 01 subtract/compare, 10 funct-decoded
//     dmem_read       data memory read request
//     dmem_write      data memory write request
//     reg_write       register file write enable
//     mem_to_reg      writeback source, 0 = ALU, 1 = memory
//     halted          sticky halt (ecall or illegal)
//     illegal         sticky illegal-opcode flag
//     retired         retired-instruction count
//     state[3:0]      current state encoding, for debug
interface multicycle_ctrl_fsm_if #(
  parameter int RETIRE_W = 32
) ();
  logic [6:0]          opcode;
  logic                zero;
  logic                imem_ready;
  logic                dmem_ready;
  logic                imem_req;
  logic                ir_write;
  logic                pc_write;
  logic                pc_branch;
  logic                alu_src;
  logic [1:0]          alu_op;
  logic                dmem_read;
  logic                dmem_write;
  logic                reg_write;
  logic                mem_to_reg;
  logic                halted;
  logic                illegal;
  logic [RETIRE_W-1:0] retired;
  logic [3:0]          state;

  modport master (
    input  opcode, zero, imem_ready, dmem_ready,
    output imem_req, ir_write, pc_write, pc_branch, alu_src, alu_op,
           dmem_read, dmem_write, reg_write, mem_to_reg, halted, illegal,
           retired, state
  );

  modport slave (
    output opcode, zero, imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_write, pc_branch, alu_src, alu_op,
           dmem_read, dmem_write, reg_write, mem_to_reg, halted, illegal,
           retired, state
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
//   Multi-cycle sequencing controller for an RV32I-subset datapath. Steps each
//   instruction through fetch / decode / execute / memory / writeback, drives
//   per-cycle datapath strobes, handshakes with wait-stating instruction and
//   data memories, counts retired instructions and halts on ecall or an
//   illegal opcode.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    multicycle_ctrl_fsm_if.master (opcode/zero/ready in, strobes,
//            retired counter and debug state out)
//   Strobes are a decode of the state register, so an asynchronous reset
//   drops every request in the same cycle. ir_write/pc_write additionally
//   depend on imem_ready in FETCH, pc_branch on zero in BRANCH.
module multicycle_ctrl_fsm #(
  parameter int RETIRE_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,
    S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10,
    S_HALT   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  state_e              state_q, state_d;
  logic [6:0]          op_q, op_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  logic       imem_req_s, ir_write_s, pc_write_s, pc_branch_s;
  logic       alu_src_s;
  logic [1:0] alu_op_s;
  logic       dmem_read_s, dmem_write_s, reg_write_s, mem_to_reg_s;
  logic       halted_s, illegal_s;
  logic       retire_s;

  // Next-state, strobe decode and retire-count update.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    imem_req_s   = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_branch_s  = 1'b0;
    alu_src_s    = 1'b0;
    alu_op_s     = 2'b00;
    dmem_read_s  = 1'b0;
    dmem_write_s = 1'b0;
    reg_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    halted_s     = 1'b0;
    illegal_s    = 1'b0;
    retire_s     = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req_s = 1'b1;
        if (bus.imem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d    = S_FETCH;
        end
      end
      S_DECODE: begin
        // op_q keeps the class for ADDR and WB_ALU, which must not rely on
        // the opcode input once DECODE is over.
        op_d = bus.opcode;
        case (bus.opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_ECALL:           state_d = S_HALT;
          default:            state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_s = 1'b0;
        alu_op_s  = 2'b10;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_s = 1'b1;
        alu_op_s  = 2'b00;
        state_d   = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b0;
        // Hold the ALU controls of whichever EXEC state led here.
        if (op_q == OP_R) begin
          alu_src_s = 1'b0;
          alu_op_s  = 2'b10;
        end else begin
          alu_src_s = 1'b1;
          alu_op_s  = 2'b00;
        end
        retire_s = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDR: begin
        alu_src_s = 1'b1;
        alu_op_s  = 2'b00;
        if (op_q == OP_LOAD) begin
          state_d = S_MEM_RD;
        end else begin
          state_d = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        dmem_read_s = 1'b1;
        alu_src_s   = 1'b1;
        if (bus.dmem_ready) begin
          state_d = S_WB_MEM;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_WB_MEM: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        retire_s     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        dmem_write_s = 1'b1;
        alu_src_s    = 1'b1;
        if (bus.dmem_ready) begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_MEM_WR;
        end
      end
      S_BRANCH: begin
        alu_src_s   = 1'b0;
        alu_op_s    = 2'b01;
        pc_branch_s = bus.zero;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: begin
        halted_s = 1'b1;
        state_d  = S_HALT;
      end
      S_TRAP: begin
        halted_s  = 1'b1;
        illegal_s = 1'b1;
        state_d   = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Plain binary add wraps from all-ones to zero.
    if (retire_s) begin
      retired_d = retired_q + RETIRE_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // State, latched opcode and retired counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 7'd0;
      retired_q <= {RETIRE_W{1'b0}};
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  assign bus.imem_req   = imem_req_s;
  assign bus.ir_write   = ir_write_s;
  assign bus.pc_write   = pc_write_s;
  assign bus.pc_branch  = pc_branch_s;
  assign bus.alu_src    = alu_src_s;
  assign bus.alu_op     = alu_op_s;
  assign bus.dmem_read  = dmem_read_s;
  assign bus.dmem_write = dmem_write_s;
  assign bus.reg_write  = reg_write_s;
  assign bus.mem_to_reg = mem_to_reg_s;
  assign bus.halted     = halted_s;
  assign bus.illegal    = illegal_s;
  assign bus.retired    = retired_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm
//   Self-checking bench for multicycle_ctrl_fsm (RETIRE_W = 4). A per-cycle
//   vector table drives opcode/zero/ready and holds the expected state,
//   strobes and retired count; hand-written sequences cover reset, sticky
//   halt/trap, counter wrap and reset abort during a store wait.
module tb_multicycle_ctrl_fsm;

  localparam int RW = 4;

  // Expected state encodings
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_EXEC_R = 4'd3;
  localparam logic [3:0] ST_EXEC_I = 4'd4;
  localparam logic [3:0] ST_ADDR   = 4'd5;
  localparam logic [3:0] ST_MEM_RD = 4'd6;
  localparam logic [3:0] ST_MEM_WR = 4'd7;
  localparam logic [3:0] ST_WB_ALU = 4'd8;
  localparam logic [3:0] ST_WB_MEM = 4'd9;
  localparam logic [3:0] ST_BRANCH = 4'd10;
  localparam logic [3:0] ST_HALT   = 4'd11;
  localparam logic [3:0] ST_TRAP   = 4'd12;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_EC  = 7'b1110011;
  localparam logic [6:0] OPC_BAD = 7'b1111111;

  // Strobe vector bit order:
  // imem_req ir_write pc_write pc_branch alu_src alu_op[1:0]
  // dmem_read dmem_write reg_write mem_to_reg halted illegal
  localparam logic [12:0] O_NONE = 13'b0_0_0_0_0_00_0_0_0_0_0_0;
  localparam logic [12:0] O_FW   = 13'b1_0_0_0_0_00_0_0_0_0_0_0;
  localparam logic [12:0] O_FG   = 13'b1_1_1_0_0_00_0_0_0_0_0_0;
  localparam logic [12:0] O_EXR  = 13'b0_0_0_0_0_10_0_0_0_0_0_0;
  localparam logic [12:0] O_EXI  = 13'b0_0_0_0_1_00_0_0_0_0_0_0;
  localparam logic [12:0] O_WBR  = 13'b0_0_0_0_0_10_0_0_1_0_0_0;
  localparam logic [12:0] O_WBI  = 13'b0_0_0_0_1_00_0_0_1_0_0_0;
  localparam logic [12:0] O_MRD  = 13'b0_0_0_0_1_00_1_0_0_0_0_0;
  localparam logic [12:0] O_WBM  = 13'b0_0_0_0_0_00_0_0_1_1_0_0;
  localparam logic [12:0] O_MWR  = 13'b0_0_0_0_1_00_0_1_0_0_0_0;
  localparam logic [12:0] O_BRT  = 13'b0_0_0_1_0_01_0_0_0_0_0_0;
  localparam logic [12:0] O_BRN  = 13'b0_0_0_0_0_01_0_0_0_0_0_0;
  localparam logic [12:0] O_HALT = 13'b0_0_0_0_0_00_0_0_0_0_1_0;
  localparam logic [12:0] O_TRAP = 13'b0_0_0_0_0_00_0_0_0_0_1_1;

  typedef struct {
    logic [6:0]  opcode;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic [3:0]  exp_state;
    logic [12:0] exp_outs;
    logic [RW-1:0] exp_retired;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vt[$];

  multicycle_ctrl_fsm_if #(.RETIRE_W(RW)) bus ();

  multicycle_ctrl_fsm #(.RETIRE_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [12:0] outs();
    return {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_branch,
            bus.alu_src, bus.alu_op, bus.dmem_read, bus.dmem_write,
            bus.reg_write, bus.mem_to_reg, bus.halted, bus.illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [6:0] opc, input logic z, input logic ir, input logic dr,
                     input logic [3:0] st, input logic [12:0] o, input logic [RW-1:0] ret);
    vec_t v;
    v.opcode = opc; v.zero = z; v.imem_ready = ir; v.dmem_ready = dr;
    v.exp_state = st; v.exp_outs = o; v.exp_retired = ret;
    vt.push_back(v);
  endtask

  task automatic drive(input logic [6:0] opc, input logic z, input logic ir, input logic dr);
    bus.opcode = opc; bus.zero = z; bus.imem_ready = ir; bus.dmem_ready = dr;
  endtask

  // Advance one clock; returns just after the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //       opcode  z  ir dr  state      outs    retired
    add(7'd0,    1'b0, 1'b1, 1'b0, ST_IDLE,   O_NONE, 4'd0);  // ready ignored in IDLE
    // R-type, zero-wait
    add(OPC_BAD, 1'b0, 1'b1, 1'b0, ST_FETCH,  O_FG,   4'd0);  // opcode ignored in FETCH
    add(OPC_R,   1'b0, 1'b0, 1'b1, ST_DECODE, O_NONE, 4'd0);  // dmem_ready ignored
    add(OPC_BAD, 1'b0, 1'b0, 1'b0, ST_EXEC_R, O_EXR,  4'd0);
    add(OPC_BAD, 1'b0, 1'b0, 1'b0, ST_WB_ALU, O_WBR,  4'd0);
    // I-type, one imem wait
    add(OPC_I,   1'b0, 1'b0, 1'b0, ST_FETCH,  O_FW,   4'd1);
    add(OPC_I,   1'b0, 1'b1, 1'b0, ST_FETCH,  O_FG,   4'd1);
    add(OPC_I,   1'b0, 1'b0, 1'b0, ST_DECODE, O_NONE, 4'd1);
    add(OPC_I,   1'b0, 1'b0, 1'b0, ST_EXEC_I, O_EXI,  4'd1);
    add(OPC_I,   1'b0, 1'b0, 1'b0, ST_WB_ALU, O_WBI,  4'd1);
    // Load, dmem_ready after 3 wait cycles: 8 cycles total
    add(OPC_LD,  1'b0, 1'b1, 1'b0, ST_FETCH,  O_FG,   4'd2);
    add(OPC_LD,  1'b0, 1'b0, 1'b0, ST_DECODE, O_NONE, 4'd2);
    add(OPC_LD,  1'b0, 1'b0, 1'b1, ST_ADDR,   O_EXI,  4'd2);  // ready without request
    add(OPC_LD,  1'b0, 1'b0, 1'b0, ST_MEM_RD, O_MRD,  4'd2);
    add(OPC_LD,  1'b0, 1'b0, 1'b0, ST_MEM_RD, O_MRD,  4'd2);
    add(OPC_LD,  1'b0, 1'b0, 1'b0, ST_MEM_RD, O_MRD,  4'd2);
    add(OPC_LD,  1'b0, 1'b0, 1'b1, ST_MEM_RD, O_MRD,  4'd2);
    add(OPC_LD,  1'b0, 1'b0, 1'b0, ST_WB_MEM, O_WBM,  4'd2);
    // Store, zero-wait
    add(OPC_ST,  1'b0, 1'b1, 1'b0, ST_FETCH,  O_FG,   4'd3);
    add(OPC_ST,  1'b0, 1'b0, 1'b0, ST_DECODE, O_NONE, 4'd3);
    add(OPC_ST,  1'b0, 1'b0, 1'b0, ST_ADDR,   O_EXI,  4'd3);
    add(OPC_ST,  1'b0, 1'b0, 1'b1, ST_MEM_WR, O_MWR,  4'd3);
    // Branch taken
    add(OPC_BR,  1'b1, 1'b1, 1'b0, ST_FETCH,  O_FG,   4'd4);
    add(OPC_BR,  1'b1, 1'b0, 1'b0, ST_DECODE, O_NONE, 4'd4);
    add(OPC_BR,  1'b1, 1'b0, 1'b0, ST_BRANCH, O_BRT,  4'd4);
    // Branch not taken
    add(OPC_BR,  1'b0, 1'b1, 1'b0, ST_FETCH,  O_FG,   4'd5);
    add(OPC_BR,  1'b0, 1'b0, 1'b0, ST_DECODE, O_NONE, 4'd5);
    add(OPC_BR,  1'b0, 1'b0, 1'b0, ST_BRANCH, O_BRN,  4'd5);
    // ecall: halted from the 3rd cycle, not counted
    add(OPC_EC,  1'b0, 1'b1, 1'b0, ST_FETCH,  O_FG,   4'd6);
    add(OPC_EC,  1'b0, 1'b0, 1'b0, ST_DECODE, O_NONE, 4'd6);
    add(OPC_EC,  1'b0, 1'b1, 1'b1, ST_HALT,   O_HALT, 4'd6);
    add(OPC_R,   1'b0, 1'b1, 1'b1, ST_HALT,   O_HALT, 4'd6);

    // ---- reset: all outputs 0 while rst_n is low, even with ready asserted
    rst_n = 1'b0;
    drive(OPC_R, 1'b1, 1'b1, 1'b1);
    step();
    step();
    check("reset outs", {19'd0, outs()}, {19'd0, O_NONE});
    check("reset state", {28'd0, bus.state}, {28'd0, ST_IDLE});
    check("reset retired", {28'd0, bus.retired}, 32'd0);
    rst_n = 1'b1;

    // ---- table-driven vectors, one per clock cycle
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].opcode, vt[i].zero, vt[i].imem_ready, vt[i].dmem_ready);
      #1;
      check($sformatf("vec%0d state", i), {28'd0, bus.state}, {28'd0, vt[i].exp_state});
      check($sformatf("vec%0d outs", i), {19'd0, outs()}, {19'd0, vt[i].exp_outs});
      check($sformatf("vec%0d retired", i), {28'd0, bus.retired}, {28'd0, vt[i].exp_retired});
      step();
    end

    // ---- HALT is sticky
    drive(OPC_R, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("halt stuck %0d", i), {19'd0, outs()}, {19'd0, O_HALT});
    end
    check("halt retired", {28'd0, bus.retired}, 32'd6);
    rst_n = 1'b0;
    #1;
    check("halt reset state", {28'd0, bus.state}, {28'd0, ST_IDLE});
    step();
    rst_n = 1'b1;

    // ---- illegal opcode -> TRAP, sticky
    drive(OPC_BAD, 1'b0, 1'b1, 1'b0);
    step();                                   // IDLE -> FETCH
    step();                                   // FETCH -> DECODE
    step();                                   // DECODE -> TRAP
    check("trap state", {28'd0, bus.state}, {28'd0, ST_TRAP});
    check("trap outs", {19'd0, outs()}, {19'd0, O_TRAP});
    drive(OPC_R, 1'b0, 1'b1, 1'b1);
    step();
    step();
    check("trap stuck", {19'd0, outs()}, {19'd0, O_TRAP});
    check("trap retired", {28'd0, bus.retired}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("trap reset outs", {19'd0, outs()}, {19'd0, O_NONE});
    step();
    rst_n = 1'b1;

    // ---- 16 branches wrap the 4-bit retired counter to 0
    drive(OPC_BR, 1'b0, 1'b1, 1'b0);
    step();                                   // IDLE -> FETCH
    for (int b = 0; b < 16; b++) begin
      step();                                 // FETCH -> DECODE
      bus.zero = b[0];
      step();                                 // DECODE -> BRANCH
      #1;
      check($sformatf("wrap br%0d state", b), {28'd0, bus.state}, {28'd0, ST_BRANCH});
      check($sformatf("wrap br%0d retired", b), {28'd0, bus.retired}, b);
      check($sformatf("wrap br%0d pc_branch", b), {31'd0, bus.pc_branch}, {31'd0, b[0]});
      step();                                 // BRANCH -> FETCH
    end
    check("wrap retired 0", {28'd0, bus.retired}, 32'd0);
    check("wrap back in fetch", {28'd0, bus.state}, {28'd0, ST_FETCH});

    // ---- reset during MEM_WR wait cycles aborts the store
    drive(OPC_ST, 1'b0, 1'b1, 1'b0);
    step();                                   // FETCH -> DECODE
    step();                                   // DECODE -> ADDR
    step();                                   // ADDR -> MEM_WR
    check("abort wr wait0", {31'd0, bus.dmem_write}, 32'd1);
    step();
    check("abort wr wait1 state", {28'd0, bus.state}, {28'd0, ST_MEM_WR});
    #2;
    rst_n = 1'b0;
    bus.dmem_ready = 1'b1;
    #1;
    check("abort dmem_write", {31'd0, bus.dmem_write}, 32'd0);
    check("abort state", {28'd0, bus.state}, {28'd0, ST_IDLE});
    step();
    check("abort retired", {28'd0, bus.retired}, 32'd0);
    rst_n = 1'b1;
    step();
    check("post-abort fetch", {31'd0, bus.imem_req}, 32'd1);
    check("post-abort retired", {28'd0, bus.retired}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
